// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: N writeback lanes, valid bit, flush,
// hold-vs-bubble stall decode, optional HI/LO path and wrapping
// retired/bubble/stall performance counters.
module mem_wb_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int LANES   = 1,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int HILO_EN = 1,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      cnt_clr,
  input  logic                      mem_valid,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  input  logic                      mem_whilo,
  input  logic [DATA_W-1:0]         mem_hi,
  input  logic [DATA_W-1:0]         mem_lo,
  output logic                      wb_valid,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic                      wb_whilo,
  output logic [DATA_W-1:0]         wb_hi,
  output logic [DATA_W-1:0]         wb_lo,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      stall_err
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD
  } act_e;

  localparam logic             HILO_ON = (HILO_EN != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s_bit;
  logic d_bit;
  logic stall_unused;
  act_e act;

  assign s_bit = stall[STAGE];

  // The downstream stage only exists if this is not the last stall bit.
  generate
    if (STAGE + 1 < STALL_W) begin : g_down
      assign d_bit = stall[STAGE+1];
    end else begin : g_no_down
      assign d_bit = 1'b0;
    end
  endgenerate

  // Other stall bits belong to other stages.
  assign stall_unused = ^stall;

  // Decode the per-edge action: flush beats stall; stall with a moving
  // downstream stage inserts a bubble, otherwise it holds.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (s_bit && !d_bit) begin
      act = ACT_BUBBLE;
    end else if (s_bit && d_bit) begin
      act = ACT_HOLD;
    end
  end

  // Pipeline register; data is captured even for invalid slots, enables are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wreg  <= '0;
      wb_wd    <= '0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else begin
      case (act)
        ACT_ADVANCE: begin
          wb_valid <= mem_valid;
          wb_wreg  <= mem_wreg & {LANES{mem_valid}};
          wb_wd    <= mem_wd;
          wb_wdata <= mem_wdata;
          wb_whilo <= HILO_ON & mem_whilo & mem_valid;
          wb_hi    <= HILO_ON ? mem_hi : '0;
          wb_lo    <= HILO_ON ? mem_lo : '0;
        end
        ACT_BUBBLE: begin
          wb_valid <= 1'b0;
          wb_wreg  <= '0;
          wb_wd    <= '0;
          wb_wdata <= '0;
          wb_whilo <= 1'b0;
          wb_hi    <= '0;
          wb_lo    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Performance counters: exactly one increments per non-reset cycle; clear overrides.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      case (act)
        ACT_ADVANCE: begin
          if (mem_valid) begin
            retire_cnt <= retire_cnt + CNT_ONE;
          end else begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
          end
        end
        ACT_BUBBLE: bubble_cnt <= bubble_cnt + CNT_ONE;
        ACT_HOLD:   stall_cnt  <= stall_cnt + CNT_ONE;
        default: ;
      endcase
    end
  end

  // Flag a downstream stall while this stage runs (non-monotonic stall vector).
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_err <= 1'b0;
    end else begin
      stall_err <= !s_bit && d_bit;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: a driver applies directed and random
// stimulus and queues the expected WB state; a monitor checks each cycle.
module tb_mem_wb_pipe;

  localparam int LANES = 2;
  localparam int CNT_M = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        mem_valid = 1'b0;
  logic [1:0]  mem_wreg = '0;
  logic [9:0]  mem_wd = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_whilo = 1'b0;
  logic [31:0] mem_hi = '0;
  logic [31:0] mem_lo = '0;

  logic        wb_valid, wb_whilo, stall_err;
  logic [1:0]  wb_wreg;
  logic [9:0]  wb_wd;
  logic [63:0] wb_wdata;
  logic [31:0] wb_hi, wb_lo;
  logic [3:0]  retire_cnt, bubble_cnt, stall_cnt;

  logic        n_valid, n_whilo, n_err;
  logic [1:0]  n_wreg;
  logic [9:0]  n_wd;
  logic [63:0] n_wdata;
  logic [31:0] n_hi, n_lo;
  logic [3:0]  n_ret, n_bub, n_stl;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(LANES), .STALL_W(6), .STAGE(4),
                .HILO_EN(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
    .stall_err(stall_err)
  );

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(LANES), .STALL_W(6), .STAGE(4),
                .HILO_EN(0), .CNT_W(4)) u_nohilo (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(n_valid), .wb_wreg(n_wreg), .wb_wd(n_wd), .wb_wdata(n_wdata),
    .wb_whilo(n_whilo), .wb_hi(n_hi), .wb_lo(n_lo),
    .retire_cnt(n_ret), .bubble_cnt(n_bub), .stall_cnt(n_stl),
    .stall_err(n_err)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  wreg;
    logic [9:0]  wd;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          ret;
    int          bub;
    int          stl;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the stage rules for one clock edge.
  task automatic step(input logic r, input logic [5:0] st, input logic fl, input logic cl,
                      input logic v, input logic [1:0] we, input logic [9:0] wd,
                      input logic [63:0] wdt, input logic wh, input logic [31:0] h,
                      input logic [31:0] l);
    logic s, d;
    @(negedge clk);
    rst = r; stall = st; flush = fl; cnt_clr = cl; mem_valid = v; mem_wreg = we;
    mem_wd = wd; mem_wdata = wdt; mem_whilo = wh; mem_hi = h; mem_lo = l;
    s = st[4];
    d = st[5];
    if (r) begin
      m = '{1'b0, 2'b0, 10'b0, 64'b0, 1'b0, 32'b0, 32'b0, 0, 0, 0, 1'b0};
    end else begin
      m.err = !s && d;
      if (fl || (s && !d)) begin
        m.valid = 0; m.wreg = 0; m.wd = 0; m.wdata = 0; m.whilo = 0; m.hi = 0; m.lo = 0;
        m.bub = (m.bub + 1) % CNT_M;
      end else if (s && d) begin
        m.stl = (m.stl + 1) % CNT_M;
      end else begin
        m.valid = v;
        m.wreg  = v ? we : 2'b00;
        m.wd    = wd;
        m.wdata = wdt;
        m.whilo = wh && v;
        m.hi    = h;
        m.lo    = l;
        if (v) m.ret = (m.ret + 1) % CNT_M;
        else   m.bub = (m.bub + 1) % CNT_M;
      end
      if (cl) begin
        m.ret = 0; m.bub = 0; m.stl = 0;
      end
    end
    q.push_back(m);
  endtask

  // Monitor: every edge presents one WB state; compare it to the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("wb_valid",   64'(wb_valid),   64'(e.valid));
      check("wb_wreg",    64'(wb_wreg),    64'(e.wreg));
      check("wb_wd",      64'(wb_wd),      64'(e.wd));
      check("wb_wdata",   wb_wdata,        e.wdata);
      check("wb_whilo",   64'(wb_whilo),   64'(e.whilo));
      check("wb_hi",      64'(wb_hi),      64'(e.hi));
      check("wb_lo",      64'(wb_lo),      64'(e.lo));
      check("retire_cnt", 64'(retire_cnt), 64'(e.ret));
      check("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
      check("stall_cnt",  64'(stall_cnt),  64'(e.stl));
      check("stall_err",  64'(stall_err),  64'(e.err));
      check("nohilo_whilo", 64'(n_whilo), 64'd0);
      check("nohilo_hi",    64'(n_hi),    64'd0);
      check("nohilo_lo",    64'(n_lo),    64'd0);
      check("nohilo_valid", 64'(n_valid), 64'(e.valid));
      check("nohilo_wdata", n_wdata,      e.wdata);
    end
  end

  initial begin
    m = '{1'b0, 2'b0, 10'b0, 64'b0, 1'b0, 32'b0, 32'b0, 0, 0, 0, 1'b0};
    // Reset state
    step(1, 6'h3f, 1, 1, 1, 2'b11, 10'h3ff, '1, 1, 32'hDEAD, 32'hBEEF);
    step(1, 6'h00, 0, 0, 1, 2'b11, 10'h155, 64'h1, 1, 32'h1, 32'h2);
    // Two-lane retire
    step(0, 6'h00, 0, 0, 1, 2'b11, {5'd3, 5'd7}, {32'hA, 32'hB}, 0, 32'h0, 32'h0);
    // Capture then hold three cycles
    step(0, 6'h00, 0, 0, 1, 2'b01, {5'd1, 5'd2}, {32'h0, 32'h55}, 1, 32'h11, 32'h22);
    for (int i = 0; i < 3; i++)
      step(0, 6'b110000, 0, 0, 1, 2'b10, 10'h2aa, 64'hFFFF, 1, 32'h99, 32'h88);
    // Stall with downstream moving: bubble
    step(0, 6'b010000, 0, 0, 1, 2'b11, 10'h123, 64'h77, 1, 32'h5, 32'h6);
    // Flush during hold
    step(0, 6'h00, 0, 0, 1, 2'b11, 10'h0ff, 64'h1234, 1, 32'h7, 32'h8);
    step(0, 6'b110000, 1, 0, 1, 2'b11, 10'h0ff, 64'h1234, 1, 32'h7, 32'h8);
    // Counter wrap after 16 retires, then clear coincident with a retire
    step(0, 6'h00, 0, 1, 1, 2'b01, 10'h001, 64'h1, 0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++)
      step(0, 6'h00, 0, 0, 1, 2'b11, 10'(i), 64'(i), 0, 32'h0, 32'h0);
    step(0, 6'h00, 0, 0, 1, 2'b11, 10'h001, 64'h5, 0, 32'h0, 32'h0);
    step(0, 6'h00, 0, 1, 1, 2'b11, 10'h002, 64'h6, 0, 32'h0, 32'h0);
    // Non-monotonic stall, then reset mid-hold
    step(0, 6'b100000, 0, 0, 1, 2'b01, 10'h00a, 64'hABC, 1, 32'hFFFF, 32'h1);
    step(0, 6'h00, 0, 0, 1, 2'b01, 10'h00b, 64'hABD, 1, 32'hFFFF, 32'h2);
    step(0, 6'b110000, 0, 0, 1, 2'b01, 10'h00c, 64'hABE, 1, 32'h3, 32'h4);
    step(1, 6'b110000, 0, 0, 1, 2'b01, 10'h00c, 64'hABE, 1, 32'h3, 32'h4);
    step(0, 6'h00, 0, 0, 0, 2'b11, 10'h3ff, 64'hF0F0, 1, 32'h3, 32'h4);
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) == 0, 6'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, 1'($urandom), 2'($urandom), 10'($urandom),
           {$urandom, $urandom}, 1'($urandom), $urandom, $urandom);
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline register, next generation of the single-lane MEM/WB latch.
- Adds: N writeback lanes, an explicit valid bit, flush, hold-vs-bubble stall decode from a generic stall vector, optional HI/LO path, and wrapping performance counters (retired / bubble / stall).
- Sits between the MEM stage and the regfile / HI-LO write ports. Counters feed the debug/CP0 read mux.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- LANES, 1, writeback lanes (1..4).
- STALL_W, 6, stall vector width.
- STAGE, 4, index of this stage in the stall vector (0..STALL_W-1).
- HILO_EN, 1, 1 = HI/LO path present; 0 = HI/LO outputs constant 0.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  pipeline stall vector, 1 = stop.
- flush  in  1  exception/ERET flush of this stage.
- cnt_clr  in  1  synchronous clear of all counters.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wreg  in  LANES  per-lane regfile write enable.
- mem_wd  in  LANES*ADDR_W  per-lane destination address; lane i at bits [i*ADDR_W +: ADDR_W].
- mem_wdata  in  LANES*DATA_W  per-lane write data; same packing as mem_wd.
- mem_whilo  in  1  HI/LO write enable.
- mem_hi  in  DATA_W  HI value.
- mem_lo  in  DATA_W  LO value.
- wb_valid  out  1  WB stage holds a real instruction.
- wb_wreg  out  LANES  per-lane write enable.
- wb_wd  out  LANES*ADDR_W  per-lane destination address.
- wb_wdata  out  LANES*DATA_W  per-lane write data.
- wb_whilo  out  1  HI/LO write enable.
- wb_hi  out  DATA_W  HI value.
- wb_lo  out  DATA_W  LO value.
- retire_cnt  out  CNT_W  count of retired instructions.
- bubble_cnt  out  CNT_W  count of bubbles captured.
- stall_cnt  out  CNT_W  count of hold cycles.
- stall_err  out  1  registered one-cycle pulse on an illegal stall pattern.

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-high (rst). All outputs registered; latency 1 cycle MEM→WB.
- Reset values: all outputs 0. wb_wd = 0 (NOP register). Counters 0. stall_err 0.
- Definitions:
  - s = stall[STAGE].
  - d = stall[STAGE+1]; d is treated as 0 when STAGE+1 ≥ STALL_W.
- Per-edge action, priority top-down:
  1. rst: reset values.
  2. flush: BUBBLE.
  3. s=1, d=0: BUBBLE. Downstream advances, so a NOP is inserted.
  4. s=1, d=1: HOLD. All wb_* keep their values.
  5. s=0: ADVANCE.
- BUBBLE: wb_valid=0; wb_wreg=0; wb_whilo=0; wb_wd, wb_wdata, wb_hi, wb_lo = 0.
- ADVANCE:
  - wb_valid ← mem_valid.
  - wb_wreg[i] ← mem_wreg[i] & mem_valid.
  - wb_whilo ← mem_whilo & mem_valid.
  - wb_wd, wb_wdata, wb_hi, wb_lo captured unmodified.
  - Data is captured even when mem_valid=0; the write enables are gated off.
- HILO_EN=0: wb_whilo, wb_hi, wb_lo are constant 0 in every state; mem_hi, mem_lo, mem_whilo are ignored.
- Counters wrap modulo 2^CNT_W. Increment rules, mutually exclusive per cycle:
  - retire_cnt +1 on ADVANCE with mem_valid=1.
  - bubble_cnt +1 on BUBBLE (flush included), or on ADVANCE with mem_valid=0.
  - stall_cnt +1 on HOLD.
- cnt_clr=1 forces all counters to 0 on that edge, overriding any increment. The pipeline datapath acts normally in the same cycle.
- rst clears the counters regardless of cnt_clr.
- stall_err:
  - Pulses 1 the cycle after an edge that saw s=0, d=1 (monotonic-stall violation). The stage still ADVANCEs on that edge.
  - Pulses only when not in rst; never pulses while rst=1.
- Flush during HOLD: flush wins and the held instruction is discarded. Flush and cnt_clr together: both take effect.
- Reset mid-hold: outputs return to reset values on the next edge; there is no held-state memory.

Test Plan:
1. LANES=2. mem_valid=1, mem_wreg=2'b11, wd={5'd3,5'd7}, wdata={32'hA,32'hB}, stall=0 → next cycle wb_valid=1, wb_wreg=2'b11, wb_wd={3,7}, wb_wdata={A,B}; retire_cnt=1.
2. stall=6'b110000 (STAGE=4) for 3 cycles after capturing wdata=32'h55 → wb_wdata stays 32'h55, wb_valid stays 1, stall_cnt=3, retire_cnt unchanged.
3. stall=6'b010000 → wb_valid=0, wb_wreg=0, wb_wd=0, wb_wdata=0; bubble_cnt +1.
4. flush=1 with stall=6'b110000 → bubble outputs next cycle; stall_cnt does not increment; bubble_cnt +1.
5. CNT_W=4: 16 consecutive retires → retire_cnt wraps to 0. cnt_clr=1 coincident with a retire → retire_cnt=0 and wb_valid=1.
6. stall=6'b100000 → stage advances and stall_err=1 for exactly one cycle. rst=1 mid-hold → all outputs 0 next edge. HILO_EN=0 with mem_whilo=1, mem_hi=32'hFFFF → wb_whilo=0, wb_hi=0.
